// File: rtl/ps2_mouse_init_seq_if.sv
// Handshake bundle between the PS/2 mouse init sequencer and its transmitter/receiver/board logic.
// master = sequencer side, slave = environment side.
interface ps2_mouse_init_seq_if;
  logic        start;
  logic [10:0] tx_frame;
  logic        tx_send;
  logic        tx_ok;
  logic        tx_err;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;
  logic        busy;
  logic        done;
  logic        fail;
  logic [3:0]  status;
  logic [1:0]  retry_cnt;

  modport master (
    input  start, tx_ok, tx_err, rx_byte, rx_valid, rx_err,
    output tx_frame, tx_send, busy, done, fail, status, retry_cnt
  );

  modport slave (
    output start, tx_ok, tx_err, rx_byte, rx_valid, rx_err,
    input  tx_frame, tx_send, busy, done, fail, status, retry_cnt
  );
endinterface

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse bring-up sequencer: Reset (FF) -> FA, AA, 00 -> Enable Reporting (F4) -> FA,
// with per-wait timeouts, Resend handling and bounded full-sequence retries.
module ps2_mouse_init_seq #(
  parameter int unsigned TIMEOUT_CYC = 25_000_000,
  parameter int unsigned BAT_TO_CYC  = 50_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                  qzt_clk,
  input logic                  reset_n,
  ps2_mouse_init_seq_if.master bus
);

  localparam int unsigned MAX_TO = (BAT_TO_CYC > TIMEOUT_CYC) ? BAT_TO_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W  = (MAX_TO > 2) ? $clog2(MAX_TO) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BAT_LAST = CNT_W'(BAT_TO_CYC - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SEND_RST = 4'd1,
    TX_RST   = 4'd2,
    ACK_RST  = 4'd3,
    BAT      = 4'd4,
    ID       = 4'd5,
    SEND_EN  = 4'd6,
    TX_EN    = 4'd7,
    ACK_EN   = 4'd8,
    DONE     = 4'd9,
    FAIL     = 4'd10
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       retry_q, retry_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_last;
  logic             tmo_hit, wait_st, do_retry, do_resend;
  logic [10:0]      tx_frame_q;
  logic             tx_send_q, busy_q, done_q, fail_q;

  function automatic logic [10:0] frame(input logic [7:0] cmd);
    return {1'b1, ~^cmd, cmd, 1'b0};
  endfunction

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_q;
    do_retry  = 1'b0;
    do_resend = 1'b0;
    wait_st   = state inside {TX_RST, TX_EN, ACK_RST, BAT, ID, ACK_EN};
    tmo_last  = (state == BAT) ? BAT_LAST : TMO_LAST;
    tmo_hit   = (tmo_cnt == tmo_last);
    unique case (state)
      IDLE, DONE, FAIL: begin
        if (bus.start) begin
          state_nxt = SEND_RST;
          retry_nxt = '0;
        end
      end
      SEND_RST: state_nxt = TX_RST;
      SEND_EN:  state_nxt = TX_EN;
      TX_RST, TX_EN: begin
        // tx_err beats tx_ok; a completed transmission beats a coincident timeout
        if (bus.tx_err)     do_retry  = 1'b1;
        else if (bus.tx_ok) state_nxt = (state == TX_RST) ? ACK_RST : ACK_EN;
        else if (tmo_hit)   do_retry  = 1'b1;
      end
      ACK_RST, BAT, ID, ACK_EN: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == RSP_RESEND)                       do_resend = 1'b1;
          else if (state == ACK_RST && bus.rx_byte == RSP_ACK)    state_nxt = BAT;
          else if (state == BAT     && bus.rx_byte == RSP_BAT_OK) state_nxt = ID;
          else if (state == ID      && bus.rx_byte == RSP_ID)     state_nxt = SEND_EN;
          else if (state == ACK_EN  && bus.rx_byte == RSP_ACK)    state_nxt = DONE;
          else                                                    do_retry  = 1'b1;
        end else if (bus.rx_err || tmo_hit) begin
          do_retry = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Resend replays the current command, a retry restarts from Reset; both consume a retry
    if (do_retry || do_resend) begin
      if (retry_q == RETRY_MAX) begin
        state_nxt = FAIL;
      end else begin
        retry_nxt = retry_q + 2'd1;
        state_nxt = (do_resend && state == ACK_EN) ? SEND_EN : SEND_RST;
      end
    end
  end

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      retry_q    <= '0;
      tmo_cnt    <= '0;
      tx_frame_q <= 11'h7FF;
      tx_send_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_q   <= retry_nxt;
      tx_send_q <= 1'b0;
      if (state_nxt != state || !wait_st) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;
      if (state == SEND_RST) begin
        tx_frame_q <= frame(CMD_RESET);
        tx_send_q  <= 1'b1;
      end else if (state == SEND_EN) begin
        tx_frame_q <= frame(CMD_ENABLE);
        tx_send_q  <= 1'b1;
      end
      busy_q <= !(state_nxt inside {IDLE, DONE, FAIL});
      done_q <= (state_nxt == DONE);
      fail_q <= (state_nxt == FAIL);
    end
  end

  assign bus.tx_frame  = tx_frame_q;
  assign bus.tx_send   = tx_send_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.status    = state;
  assign bus.retry_cnt = retry_q;

endmodule
